uart_alu_ctrl: RTL
==================

# uart_alu_ctrl

Sequencing controller between the UART receiver, the ALU and the UART transmitter. It collects three bytes from the receiver in order: operand A, operand B, opcode. It drives the ALU with them, captures the result and hands it to the transmitter. It then waits for transmission to complete before accepting a new command, and aborts partially received commands after an inactivity timeout.

## Interface
- NDATA_BITS, 8, width of UART data byte, ALU operands and result
- NOP_BITS, 6, ALU opcode width; taken from i_rx_data[NOP_BITS-1:0]
- TIMEOUT_CYCLES, 1000000, i_clock cycles allowed between bytes of one command; minimum 2

- i_clock  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_rx_data  in  NDATA_BITS  byte from UART receiver, valid when i_rx_done=1
- i_rx_done  in  1  one-cycle pulse, byte received
- i_alu_result  in  NDATA_BITS  combinational ALU result for o_alu_a/o_alu_b/o_alu_op
- i_tx_done  in  1  one-cycle pulse, transmitter finished current byte
- o_alu_a  out  NDATA_BITS  registered operand A
- o_alu_b  out  NDATA_BITS  registered operand B
- o_alu_op  out  NOP_BITS  registered opcode
- o_tx_data  out  NDATA_BITS  registered result byte to transmitter
- o_tx_start  out  1  one-cycle pulse, start transmission of o_tx_data
- o_busy  out  1  high in EXEC, SEND, WAIT_TX
- o_overrun  out  1  one-cycle pulse, received byte dropped
- o_timeout  out  1  one-cycle pulse, partial command aborted

## Operation
- Reset: state WAIT_A; o_alu_a, o_alu_b, o_alu_op, o_tx_data = 0; o_tx_start, o_overrun, o_timeout = 0; timeout counter = 0.
- Reset wins over every other input. Reset mid-command discards any partial command. No o_timeout or o_overrun pulse results from a reset.
- WAIT_A: i_rx_done -> o_alu_a <= i_rx_data, clear counter, go to WAIT_B. No timeout in this state.
- WAIT_B: i_rx_done -> o_alu_b <= i_rx_data, clear counter, go to WAIT_OP.
- WAIT_OP: i_rx_done -> o_alu_op <= i_rx_data[NOP_BITS-1:0] (upper bits ignored), go to EXEC.
- Timeout in WAIT_B/WAIT_OP: counter increments each cycle without i_rx_done.
  - When the counter equals TIMEOUT_CYCLES-1 and no i_rx_done is present: go to WAIT_A, pulse o_timeout, clear counter.
  - The captured operands keep their values.
  - If i_rx_done coincides with expiry, the byte is accepted and no timeout occurs.
- EXEC, one cycle: o_tx_data <= i_alu_result, go to SEND.
- SEND, one cycle: o_tx_start = 1, go to WAIT_TX.
- WAIT_TX: on i_tx_done go to WAIT_A. No timeout; waits indefinitely.
- Byte dropped while busy: i_rx_done in EXEC, SEND or WAIT_TX (including the same cycle as i_tx_done) -> byte dropped, o_overrun pulses the next cycle, all registers unchanged.
- Stray done pulse: i_tx_done outside WAIT_TX is ignored.
- o_alu_a/b/op hold their values after a command completes, until overwritten by the next command.

## Timing
- All outputs registered; o_busy decoded from the state register.
- Opcode accepted (i_rx_done in WAIT_OP) at cycle n:
  - n+1: o_alu_op valid, state EXEC.
  - n+2: o_tx_data = result, o_tx_start = 1.
  - n+3: state WAIT_TX.
- i_tx_done at cycle m -> state WAIT_A at m+1; an i_rx_done at m+1 is accepted as operand A.
- Back-to-back i_rx_done on consecutive cycles in WAIT_A/WAIT_B/WAIT_OP are all accepted, one byte per cycle.
- o_overrun and o_timeout assert in the cycle after the causing event, for exactly one cycle.

## Test plan
- Basic command: A=0x05, B=0x03, op=0x20, ALU model = add.
  - o_alu_a=0x05, o_alu_b=0x03, o_alu_op=0x20.
  - o_tx_data=0x08 and o_tx_start high exactly 2 cycles after the opcode i_rx_done.
  - i_tx_done returns the block to WAIT_A, o_busy low.
- Opcode masking: opcode byte 0xE2, NOP_BITS=6 -> o_alu_op=0x22.
- Timeout, TIMEOUT_CYCLES=16:
  - Send A=0x11, then nothing -> o_timeout pulses once 16 cycles later; state WAIT_A; o_alu_a stays 0x11.
  - Next bytes 0x01, 0x02, op complete a normal command.
- Timeout boundary: B arrives on exactly the expiry cycle -> accepted, no o_timeout, state WAIT_OP.
- Overrun: send byte 0x7F during WAIT_TX -> o_overrun pulse, no register change; after i_tx_done, a fresh command executes correctly.
- Reset mid-command: assert i_reset while in WAIT_OP -> all outputs 0, state WAIT_A, no pulses; following command A=0xFF, B=0x01 produces the expected result.

Source files
------------

// File: rtl/uart_alu_ctrl.sv
// uart_alu_ctrl: sequences UART receiver -> ALU -> UART transmitter.
// Collects operand A, operand B and an opcode byte, and latches the ALU result.
// It then starts a transmission and waits for it to finish.
// A partial command is aborted if too many cycles pass between its bytes.
module uart_alu_ctrl #(
  parameter int unsigned NDATA_BITS     = 8,
  parameter int unsigned NOP_BITS       = 6,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [NDATA_BITS-1:0] i_rx_data,
  input  logic                  i_rx_done,
  input  logic [NDATA_BITS-1:0] i_alu_result,
  input  logic                  i_tx_done,
  output logic [NDATA_BITS-1:0] o_alu_a,
  output logic [NDATA_BITS-1:0] o_alu_b,
  output logic [NOP_BITS-1:0]   o_alu_op,
  output logic [NDATA_BITS-1:0] o_tx_data,
  output logic                  o_tx_start,
  output logic                  o_busy,
  output logic                  o_overrun,
  output logic                  o_timeout
);

  localparam int unsigned    CW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EXEC,
    SEND,
    WAIT_TX
  } state_t;

  state_t                state_q;
  logic [CW-1:0]         cnt_q;
  logic [NDATA_BITS-1:0] alu_a_q;
  logic [NDATA_BITS-1:0] alu_b_q;
  logic [NOP_BITS-1:0]   alu_op_q;
  logic [NDATA_BITS-1:0] tx_data_q;
  logic                  tx_start_q;
  logic                  overrun_q;
  logic                  timeout_q;

  // Command sequencer: byte capture, inter-byte timeout, execute/send handshake.
  // o_tx_start is raised on the EXEC->SEND transition so it is high while in SEND.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= WAIT_A;
      cnt_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      overrun_q  <= 1'b0;
      timeout_q  <= 1'b0;
      case (state_q)
        WAIT_A: begin
          if (i_rx_done) begin
            alu_a_q <= i_rx_data;
            cnt_q   <= '0;
            state_q <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (i_rx_done) begin
            alu_b_q <= i_rx_data;
            cnt_q   <= '0;
            state_q <= WAIT_OP;
          end else if (cnt_q == CNT_LAST) begin
            timeout_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= WAIT_A;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WAIT_OP: begin
          if (i_rx_done) begin
            alu_op_q <= i_rx_data[NOP_BITS-1:0];
            cnt_q    <= '0;
            state_q  <= EXEC;
          end else if (cnt_q == CNT_LAST) begin
            timeout_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= WAIT_A;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        EXEC: begin
          overrun_q  <= i_rx_done;
          tx_data_q  <= i_alu_result;
          tx_start_q <= 1'b1;
          state_q    <= SEND;
        end
        SEND: begin
          overrun_q <= i_rx_done;
          state_q   <= WAIT_TX;
        end
        WAIT_TX: begin
          overrun_q <= i_rx_done;
          if (i_tx_done) begin
            state_q <= WAIT_A;
          end
        end
        default: begin
          state_q <= WAIT_A;
        end
      endcase
    end
  end

  assign o_alu_a    = alu_a_q;
  assign o_alu_b    = alu_b_q;
  assign o_alu_op   = alu_op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_overrun  = overrun_q;
  assign o_timeout  = timeout_q;
  assign o_busy     = (state_q == EXEC) || (state_q == SEND) || (state_q == WAIT_TX);

endmodule
